// File: rtl/voice_scheduler_if.sv
// voice_scheduler_if: note-change command type and the note-in / voice-out bundle
// between MIDI decode, the voice scheduler and the per-voice pipelines.
interface voice_scheduler_if #(parameter int PIPELINE_COUNT = 4);
    typedef struct packed {
        logic       status;
        logic [6:0] note_number;
        logic [6:0] velocity;
    } note_change_t;

    note_change_t                      note;
    logic                              note_ready;
    logic                              panic;
    note_change_t [PIPELINE_COUNT-1:0] pipeline_notes;
    logic [PIPELINE_COUNT-1:0]         pipeline_notes_ready;
    logic [PIPELINE_COUNT-1:0]         voice_busy;

    modport master (
        output note, note_ready, panic,
        input  pipeline_notes, pipeline_notes_ready, voice_busy
    );
    modport slave (
        input  note, note_ready, panic,
        output pipeline_notes, pipeline_notes_ready, voice_busy
    );
endinterface

// File: rtl/voice_scheduler.sv
// voice_scheduler: allocates note on/off commands across PIPELINE_COUNT voices with
// retrigger, free-first, LRU stealing, timed release and panic; status 1 = ON.
module voice_scheduler #(
    parameter int          PIPELINE_COUNT = 4,
    parameter logic [23:0] RELEASE_CYCLES = 24'd5_000_000
) (
    input logic              clock_50_000_000,
    input logic              reset_l,
    voice_scheduler_if.slave bus
);
    localparam int IW = $clog2(PIPELINE_COUNT);

    typedef enum logic [1:0] {FREE, HELD, RELEASING} voice_state_t;

    voice_state_t                     state      [PIPELINE_COUNT];
    voice_state_t                     state_n    [PIPELINE_COUNT];
    logic [6:0]                       note_num   [PIPELINE_COUNT];
    logic [6:0]                       note_num_n [PIPELINE_COUNT];
    logic [23:0]                      cnt        [PIPELINE_COUNT];
    logic [23:0]                      cnt_n      [PIPELINE_COUNT];
    logic [IW-1:0]                    rank       [PIPELINE_COUNT];
    logic [IW-1:0]                    rank_n     [PIPELINE_COUNT];
    logic [PIPELINE_COUNT-1:0][14:0]  cmd, cmd_n;
    logic [PIPELINE_COUNT-1:0]        strobe, strobe_n, busy, busy_n;

    logic          on_req, off_req;
    logic [6:0]    nn;
    logic          hit_found, free_found, rel_found, off_found;
    logic [IW-1:0] hit_idx, free_idx, rel_idx, held_idx, off_idx, alloc;
    logic [IW-1:0] rel_rank, held_rank;

    assign nn      = bus.note.note_number;
    assign on_req  = bus.note_ready && !bus.panic && bus.note.status && bus.note.velocity != 7'd0;
    assign off_req = bus.note_ready && !bus.panic && !on_req;

    assign bus.pipeline_notes       = cmd;
    assign bus.pipeline_notes_ready = strobe;
    assign bus.voice_busy           = busy;

    // Voice selection from registered state; the downward scan leaves the lowest index.
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        rel_found  = 1'b0;
        rel_idx    = '0;
        rel_rank   = '0;
        held_idx   = '0;
        held_rank  = '0;
        off_found  = 1'b0;
        off_idx    = '0;
        for (int i = PIPELINE_COUNT - 1; i >= 0; i--) begin
            if (state[i] != FREE && note_num[i] == nn) begin
                hit_found = 1'b1;
                hit_idx   = IW'(i);
            end
            if (state[i] == FREE) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (state[i] == HELD && note_num[i] == nn) begin
                off_found = 1'b1;
                off_idx   = IW'(i);
            end
            if (state[i] == RELEASING && (!rel_found || rank[i] > rel_rank)) begin
                rel_found = 1'b1;
                rel_idx   = IW'(i);
                rel_rank  = rank[i];
            end
            if (state[i] == HELD && rank[i] >= held_rank) begin
                held_idx  = IW'(i);
                held_rank = rank[i];
            end
        end
        alloc = hit_found ? hit_idx : free_found ? free_idx : rel_found ? rel_idx : held_idx;
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < PIPELINE_COUNT; i++) begin
                state[i]    <= FREE;
                note_num[i] <= '0;
                cnt[i]      <= '0;
                rank[i]     <= IW'(i);
            end
            cmd    <= '0;
            strobe <= '0;
            busy   <= '0;
        end else begin
            state    <= state_n;
            note_num <= note_num_n;
            cnt      <= cnt_n;
            rank     <= rank_n;
            cmd      <= cmd_n;
            strobe   <= strobe_n;
            busy     <= busy_n;
        end
    end

    // An allocation is applied after the release countdown so it overrides a same-cycle expiry.
    always_comb begin
        state_n    = state;
        note_num_n = note_num;
        cnt_n      = cnt;
        rank_n     = rank;
        for (int i = 0; i < PIPELINE_COUNT; i++) begin
            if (state[i] == RELEASING) begin
                if (cnt[i] == 24'd0) state_n[i] = FREE;
                else cnt_n[i] = cnt[i] - 24'd1;
            end
        end
        if (bus.panic) begin
            for (int i = 0; i < PIPELINE_COUNT; i++) begin
                state_n[i] = FREE;
                cnt_n[i]   = '0;
            end
        end else if (on_req) begin
            state_n[alloc]    = HELD;
            note_num_n[alloc] = nn;
            cnt_n[alloc]      = '0;
            for (int i = 0; i < PIPELINE_COUNT; i++)
                if (rank[i] < rank[alloc]) rank_n[i] = rank[i] + IW'(1);
            rank_n[alloc] = '0;
        end else if (off_req && off_found) begin
            state_n[off_idx] = RELEASING;
            cnt_n[off_idx]   = RELEASE_CYCLES - 24'd1;
        end
    end

    always_comb begin
        strobe_n = '0;
        cmd_n    = cmd;
        busy_n   = '0;
        for (int i = 0; i < PIPELINE_COUNT; i++) busy_n[i] = state_n[i] != FREE;
        if (bus.panic) begin
            for (int i = 0; i < PIPELINE_COUNT; i++) begin
                if (state[i] != FREE) begin
                    strobe_n[i] = 1'b1;
                    cmd_n[i]    = {1'b0, note_num[i], 7'd0};
                end
            end
        end else if (on_req) begin
            strobe_n[alloc] = 1'b1;
            cmd_n[alloc]    = bus.note;
        end else if (off_req && off_found) begin
            strobe_n[off_idx] = 1'b1;
            cmd_n[off_idx]    = {1'b0, nn, bus.note.velocity};
        end
    end
endmodule
